assoc_cache_ctrl: RTL and testbench
===================================

// Module: assoc_cache_ctrl
// PURPOSE
// - Parametrised N-way set-associative read cache between MEM stage and SRAM controller.
// - Read hits return same cycle; misses fill a whole line from SRAM, then return the word.
// - Writes go through to SRAM and update a hit line in place; a write never allocates.
// - Adds over the 2-way generation:
//   - configurable ways, sets, tag and line width
//   - explicit FSM with held SRAM handshake
//   - tree-PLRU replacement
//   - flush input
//   - saturating hit/miss counters
// PARAMETERS
// - ADDR_W   32  request address width
// - WORD_W   32  CPU word width
// - LINE_W   64  line width; LINE_W/WORD_W words per line, power of 2
// - INDEX_W  6   set index bits (2**INDEX_W sets)
// - TAG_W    9   tag bits, taken directly above the index; higher address bits are ignored
// - WAYS     2   associativity; 2 or 4 only
// - CNT_W    16  statistics counter width
// PORTS
// - clk           in   1        clock, rising edge
// - rst           in   1        reset, synchronous, active-high
// - mem_r_en      in   1        read request, held until ready
// - mem_w_en      in   1        write request, held until ready; wins over mem_r_en
// - flush         in   1        invalidate all lines; honoured only in IDLE with no request
// - address       in   ADDR_W   byte address; stable while a request is held
// - wdata         in   WORD_W   write data
// - rdata         out  WORD_W   read data, valid when ready & mem_r_en
// - ready         out  1        request complete this cycle
// - hit           out  1        combinational lookup hit for current address
// - sram_address  out  ADDR_W   fills: line-aligned address; writes: address
// - sram_wdata    out  WORD_W   = wdata
// - sram_read     out  1        line read request, held until sram_ready
// - sram_write    out  1        word write request, held until sram_ready
// - sram_rdata    in   LINE_W   fill line, valid with sram_ready
// - sram_ready    in   1        SRAM transfer done, one-cycle pulse
// - hit_cnt       out  CNT_W    completed read hits, saturating
// - miss_cnt      out  CNT_W    completed read misses, saturating
// BEHAVIOUR
// - Address fields, low to high:
//   - OFF_W = log2(LINE_W/8): byte offset within the line
//   - word select = address[OFF_W-1:log2(WORD_W/8)]
//   - index = next INDEX_W bits
//   - tag = next TAG_W bits
// - Per way per set: valid, tag, line. Per set: PLRU state, WAYS-1 bits.
// - Reset:
//   - all valid and PLRU bits cleared; FSM goes to IDLE
//   - ready, sram_read, sram_write = 0; counters = 0
// - FSM states IDLE, FILL, WRITE.
// - IDLE, mem_w_en:
//   - next state WRITE; ready=0
// - IDLE, mem_r_en & hit:
//   - ready=1 combinationally, rdata from the hit way
//   - hit way made MRU; hit_cnt+1
// - IDLE, mem_r_en & ~hit:
//   - next state FILL; ready=0
// - FILL:
//   - sram_read=1 until sram_ready
//   - on the sram_ready cycle:
//     - victim = lowest-index invalid way, else PLRU victim
//     - write line, tag and valid=1 into the victim; victim made MRU
//     - rdata = selected word of sram_rdata; ready=1; miss_cnt+1
//     - next state IDLE
// - WRITE:
//   - sram_write=1 until sram_ready
//   - on the sram_ready cycle: if hit, overwrite the selected word of the hit line (valid kept); ready=1; next state IDLE
//   - PLRU is not touched by writes
// - Latency:
//   - read hit: 0 cycles
//   - read miss: 1 + SRAM cycles
//   - write: 1 + SRAM cycles
// - mem_r_en & mem_w_en together: treated as a write; the read is ignored.
// - flush: all valid bits cleared at the next edge; PLRU bits cleared.
// - Request dropped mid-FILL/WRITE is illegal; the SRAM transaction still completes.
// - rst mid-operation: FSM to IDLE next edge; sram_read/sram_write low; a late sram_ready is ignored.
// - PLRU:
//   - WAYS=2: 1 bit, pointing at the LRU way
//   - WAYS=4: 3-bit tree; b0 picks half, b1/b2 pick way within that half; update points bits away from the accessed way
// - Counters stop at 2**CNT_W-1.
// STRUCTURE
// - cache_defs.vh: state encodings, OFF_W/word-select localparam formulas, WAYS legality check.
// - Sub-module plru_tree (#WAYS):
//   - inputs: state, access_way, access_en
//   - outputs: victim_way, next_state
// - Tag/valid/data arrays stay flat registers in this module.
// TESTING
// - Cold read 0x0000_0104 with sram_rdata=64'hAAAA_BBBB_1111_2222:
//   - sram_read held until sram_ready
//   - rdata=32'hAAAA_BBBB; hit then 1; miss_cnt=1
// - Re-read 0x0000_0100 -> ready same cycle, rdata=32'h1111_2222, hit_cnt=1, no sram_read.
// - WAYS=4: fill 4 tags into index 0, touch ways 0,2, then miss a 5th tag:
//   - victim is way 1 (PLRU); way 0 and way 2 still hit
// - Write 0xDEAD_BEEF to 0x0000_0100 (hit):
//   - sram_write held until sram_ready, ready=1
//   - re-read gives 0xDEAD_BEEF without SRAM access
// - Write to an uncached address -> no allocation; a following read of that address misses.
// - Assert rst during FILL before sram_ready:
//   - next cycle sram_read=0, ready=0, all lookups miss, counters 0
// - Assert flush, then re-read -> all lookups miss.

Source files
------------

// File: rtl/assoc_cache_ctrl_pkg.sv
// Shared types and address-field helpers for the set-associative read cache.
package assoc_cache_ctrl_pkg;

  typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

  // Number of byte-offset bits for an item of the given bit width.
  function automatic int unsigned byte_off_bits(int unsigned bits);
    return $clog2(bits / 8);
  endfunction

endpackage

// File: rtl/assoc_cache_ctrl_if.sv
// CPU-side request bus of the cache: held request in, same-cycle or late completion out.
interface assoc_cache_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32
);
  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] address;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              ready;
  logic              hit;

  modport master (output mem_r_en, mem_w_en, address, wdata, input rdata, ready, hit);
  modport slave  (input mem_r_en, mem_w_en, address, wdata, output rdata, ready, hit);
endinterface

// File: rtl/assoc_cache_ctrl_plru_tree.sv
// Tree pseudo-LRU for 2 or 4 ways: names the victim and computes the post-access state.
module assoc_cache_ctrl_plru_tree #(
  parameter int unsigned WAYS = 2,
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  state_i,
  input  logic [WAY_W-1:0] access_way_i,
  input  logic             access_en_i,
  output logic [WAY_W-1:0] victim_way_o,
  output logic [WAYS-2:0]  next_state_o
);

  if (WAYS == 2) begin : g_two
    always_comb begin
      victim_way_o = state_i[0];
      next_state_o = state_i;
      if (access_en_i) next_state_o[0] = ~access_way_i[0];
    end
  end else begin : g_four
    // b0 selects the victim half; b1/b2 select the way inside half 0/1.
    always_comb begin
      victim_way_o = state_i[0] ? {1'b1, state_i[2]} : {1'b0, state_i[1]};
      next_state_o = state_i;
      if (access_en_i) begin
        next_state_o[0] = ~access_way_i[1];
        if (access_way_i[1]) next_state_o[2] = ~access_way_i[0];
        else                 next_state_o[1] = ~access_way_i[0];
      end
    end
  end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative read cache with write-through, no write-allocate, PLRU and flush.
module assoc_cache_ctrl
  import assoc_cache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned LINE_W  = 64,
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 9,
  parameter int unsigned WAYS    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  assoc_cache_ctrl_if.slave    bus,
  input  logic                 flush,
  output logic [ADDR_W-1:0]    sram_address,
  output logic [WORD_W-1:0]    sram_wdata,
  output logic                 sram_read,
  output logic                 sram_write,
  input  logic [LINE_W-1:0]    sram_rdata,
  input  logic                 sram_ready,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt
);

  localparam int unsigned SETS    = 2 ** INDEX_W;
  localparam int unsigned WPL     = LINE_W / WORD_W;
  localparam int unsigned OFF_W   = byte_off_bits(LINE_W);
  localparam int unsigned WSEL_LO = byte_off_bits(WORD_W);
  localparam int unsigned WSEL_W  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int unsigned WAY_W   = $clog2(WAYS);

  state_e                state_q, state_d;
  logic                  sram_read_q, sram_read_d, sram_write_q, sram_write_d;
  logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       valid_d [SETS];
  logic [WAYS-2:0]       plru_q  [SETS];
  logic [WAYS-2:0]       plru_d  [SETS];
  logic [TAG_W-1:0]      tag_q   [WAYS][SETS];
  logic [TAG_W-1:0]      tag_d   [WAYS][SETS];
  logic [LINE_W-1:0]     line_q  [WAYS][SETS];
  logic [LINE_W-1:0]     line_d  [WAYS][SETS];

  logic [INDEX_W-1:0]    idx;
  logic [TAG_W-1:0]      tag;
  logic [WSEL_W-1:0]     wsel;
  logic [WAYS-1:0]       hit_way;
  logic [WAY_W-1:0]      hit_idx, free_idx, victim, plru_victim, plru_way;
  logic                  inv_found, hit, plru_en;
  logic [WAYS-2:0]       plru_next;
  logic [LINE_W-1:0]     hit_line;

  assign idx  = bus.address[OFF_W +: INDEX_W];
  assign tag  = bus.address[OFF_W + INDEX_W +: TAG_W];
  assign wsel = (WPL > 1) ? bus.address[WSEL_LO +: WSEL_W] : '0;

  // Descending scans so the lowest-numbered matching way wins.
  always_comb begin
    hit_way   = '0;
    hit_idx   = '0;
    inv_found = 1'b0;
    free_idx  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
        hit_way[w] = 1'b1;
        hit_idx    = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        free_idx  = WAY_W'(w);
      end
    end
  end

  assign hit      = |hit_way;
  assign bus.hit  = hit;
  assign hit_line = line_q[hit_idx][idx];
  assign victim   = inv_found ? free_idx : plru_victim;
  assign plru_way = (state_q == StFill) ? victim : hit_idx;
  assign plru_en  = (state_q == StIdle && !bus.mem_w_en && bus.mem_r_en && hit) ||
                    (state_q == StFill && sram_ready);

  assoc_cache_ctrl_plru_tree #(.WAYS(WAYS)) u_plru (
    .state_i      (plru_q[idx]),
    .access_way_i (plru_way),
    .access_en_i  (plru_en),
    .victim_way_o (plru_victim),
    .next_state_o (plru_next)
  );

  always_comb begin
    state_d      = state_q;
    sram_read_d  = sram_read_q;
    sram_write_d = sram_write_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    valid_d      = valid_q;
    plru_d       = plru_q;
    tag_d        = tag_q;
    line_d       = line_q;
    plru_d[idx]  = plru_next;
    bus.ready    = 1'b0;
    bus.rdata    = hit_line[wsel * WORD_W +: WORD_W];
    unique case (state_q)
      StIdle: begin
        if (bus.mem_w_en) begin
          state_d      = StWrite;
          sram_write_d = 1'b1;
        end else if (bus.mem_r_en) begin
          if (hit) begin
            bus.ready = 1'b1;
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
          end else begin
            state_d     = StFill;
            sram_read_d = 1'b1;
          end
        end else if (flush) begin
          for (int s = 0; s < SETS; s++) begin
            valid_d[s] = '0;
            plru_d[s]  = '0;
          end
        end
      end
      StFill: begin
        bus.rdata = sram_rdata[wsel * WORD_W +: WORD_W];
        if (sram_ready) begin
          state_d                = StIdle;
          sram_read_d            = 1'b0;
          bus.ready              = 1'b1;
          valid_d[idx][victim]   = 1'b1;
          tag_d[victim][idx]     = tag;
          line_d[victim][idx]    = sram_rdata;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
        end
      end
      StWrite: begin
        if (sram_ready) begin
          state_d      = StIdle;
          sram_write_d = 1'b0;
          bus.ready    = 1'b1;
          if (hit) line_d[hit_idx][idx][wsel * WORD_W +: WORD_W] = bus.wdata;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sram_read_q  <= 1'b0;
      sram_write_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      sram_read_q  <= sram_read_d;
      sram_write_q <= sram_write_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      valid_q      <= valid_d;
      plru_q       <= plru_d;
    end
  end

  // Tag and data storage are qualified by valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    line_q <= line_d;
  end

  assign sram_read    = sram_read_q;
  assign sram_write   = sram_write_q;
  assign hit_cnt      = hit_cnt_q;
  assign miss_cnt     = miss_cnt_q;
  assign sram_wdata   = bus.wdata;
  assign sram_address = (state_q == StWrite) ? bus.address
                                             : {bus.address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl (4-way, 4-bit counters) against a 2-cycle SRAM model.
module tb_assoc_cache_ctrl;

  localparam int SRAM_LAT = 2;
  localparam int MAX_CYC  = 20;

  typedef struct {
    logic        wr;
    logic        both;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [63:0] line;
    logic        exp_hit;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_sr;
    int          exp_sw;
    int          exp_hc;
    int          exp_mc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] sram_address, sram_wdata;
  logic        sram_read, sram_write;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  logic [3:0]  hit_cnt, miss_cnt;

  logic        resp_en;
  logic [63:0] resp_line;
  int          resp_wait;
  int          checks = 0;
  int          errors = 0;
  vec_t        vq[$];

  assoc_cache_ctrl_if #(.ADDR_W(32), .WORD_W(32)) bus ();

  assoc_cache_ctrl #(.WAYS(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .flush        (flush),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_read    (sram_read),
    .sram_write   (sram_write),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle ready pulse after SRAM_LAT cycles of a held request.
  always @(posedge clk) begin
    #1;
    if (sram_ready) sram_ready = 1'b0;
    else if (resp_en && (sram_read || sram_write)) begin
      if (resp_wait == SRAM_LAT - 1) begin
        sram_ready = 1'b1;
        sram_rdata = resp_line;
        resp_wait  = 0;
      end else resp_wait++;
    end else resp_wait = 0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic wr, input logic both, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [63:0] line, input logic exp_hit,
                      input logic chk_rd, input logic [31:0] exp_rd, input int exp_sr,
                      input int exp_sw, input int exp_hc, input int exp_mc);
    vec_t v;
    v.wr = wr; v.both = both; v.addr = addr; v.wd = wd; v.line = line;
    v.exp_hit = exp_hit; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    v.exp_sr = exp_sr; v.exp_sw = exp_sw; v.exp_hc = exp_hc; v.exp_mc = exp_mc;
    vq.push_back(v);
  endtask

  // Called just after a rising edge; returns just after the completing edge.
  task automatic xact(input logic wr, input logic both, input logic [31:0] a,
                      input logic [31:0] wd, input logic [63:0] line,
                      output logic [31:0] rd, output logic h0, output int cyc,
                      output int sr, output int sw, output logic [31:0] saddr);
    bus.mem_w_en = wr;
    bus.mem_r_en = ~wr | both;
    bus.address  = a;
    bus.wdata    = wd;
    resp_line    = line;
    rd = '0; h0 = 1'b0; cyc = -1; sr = 0; sw = 0; saddr = '0;
    for (int k = 0; k < MAX_CYC; k++) begin
      @(negedge clk);
      if (k == 0) h0 = bus.hit;
      if (sram_read)  begin sr++; saddr = sram_address; end
      if (sram_write) begin sw++; saddr = sram_address; end
      if (bus.ready) begin
        rd  = bus.rdata;
        cyc = k;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, saddr, exp_saddr;
    logic        h0;
    int          cyc, sr, sw;

    rst = 1'b1; flush = 1'b0; resp_en = 1'b1; resp_wait = 0; resp_line = '0;
    sram_ready = 1'b0; sram_rdata = '0;
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0; bus.address = 32'h104; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.ready", bus.ready, 1'b0);
    chk("rst.sram_read", sram_read, 1'b0);
    chk("rst.sram_write", sram_write, 1'b0);
    chk("rst.hit", bus.hit, 1'b0);
    chk("rst.hit_cnt", hit_cnt, 4'd0);
    chk("rst.miss_cnt", miss_cnt, 4'd0);
    @(posedge clk);
    #1;

    //   wr both addr          wdata         line                    hit rd? rdata       sr sw hc mc
    addv(0, 0, 32'h0000_0104, 32'h0,         64'hAAAA_BBBB_1111_2222, 0, 1, 32'hAAAA_BBBB, 2, 0, 0, 1);
    addv(0, 0, 32'h0000_0100, 32'h0,         64'h0,                   1, 1, 32'h1111_2222, 0, 0, 1, 1);
    addv(1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 64'h0,                   1, 0, 32'h0,         0, 2, 1, 1);
    addv(0, 0, 32'h0000_0100, 32'h0,         64'h0,                   1, 1, 32'hDEAD_BEEF, 0, 0, 2, 1);
    addv(0, 0, 32'h0000_0104, 32'h0,         64'h0,                   1, 1, 32'hAAAA_BBBB, 0, 0, 3, 1);
    addv(1, 0, 32'h0000_2000, 32'h5555_AAAA, 64'h0,                   0, 0, 32'h0,         0, 2, 3, 1);
    addv(0, 0, 32'h0000_2000, 32'h0,         64'h1234_5678_9ABC_DEF0, 0, 1, 32'h9ABC_DEF0, 2, 0, 3, 2);
    addv(0, 0, 32'h0000_2200, 32'h0,         64'h1100_0001_1100_0000, 0, 1, 32'h1100_0000, 2, 0, 3, 3);
    addv(0, 0, 32'h0000_2400, 32'h0,         64'h1200_0001_1200_0000, 0, 1, 32'h1200_0000, 2, 0, 3, 4);
    addv(0, 0, 32'h0000_2604, 32'h0,         64'h1300_0001_1300_0000, 0, 1, 32'h1300_0001, 2, 0, 3, 5);
    addv(0, 0, 32'h0000_2000, 32'h0,         64'h0,                   1, 1, 32'h9ABC_DEF0, 0, 0, 4, 5);
    addv(0, 0, 32'h0000_2404, 32'h0,         64'h0,                   1, 1, 32'h1200_0001, 0, 0, 5, 5);
    addv(0, 0, 32'h0000_2800, 32'h0,         64'h1400_0001_1400_0000, 0, 1, 32'h1400_0000, 2, 0, 5, 6);
    addv(0, 0, 32'h0000_2000, 32'h0,         64'h0,                   1, 1, 32'h9ABC_DEF0, 0, 0, 6, 6);
    addv(0, 0, 32'h0000_2400, 32'h0,         64'h0,                   1, 1, 32'h1200_0000, 0, 0, 7, 6);
    addv(0, 0, 32'h0000_2604, 32'h0,         64'h0,                   1, 1, 32'h1300_0001, 0, 0, 8, 6);
    addv(0, 0, 32'h0000_2200, 32'h0,         64'h2100_0001_2100_0000, 0, 1, 32'h2100_0000, 2, 0, 8, 7);

    foreach (vq[i]) begin
      xact(vq[i].wr, vq[i].both, vq[i].addr, vq[i].wd, vq[i].line, rd, h0, cyc, sr, sw, saddr);
      exp_saddr = vq[i].wr ? vq[i].addr : {vq[i].addr[31:3], 3'b000};
      chk($sformatf("v%0d.hit", i), h0, vq[i].exp_hit);
      chk($sformatf("v%0d.latency", i), cyc, (vq[i].exp_sr + vq[i].exp_sw > 0) ? SRAM_LAT : 0);
      chk($sformatf("v%0d.sram_read_cyc", i), sr, vq[i].exp_sr);
      chk($sformatf("v%0d.sram_write_cyc", i), sw, vq[i].exp_sw);
      if (sr + sw > 0) chk($sformatf("v%0d.sram_address", i), saddr, exp_saddr);
      if (vq[i].chk_rd) chk($sformatf("v%0d.rdata", i), rd, vq[i].exp_rd);
      chk($sformatf("v%0d.hit_cnt", i), hit_cnt, vq[i].exp_hc);
      chk($sformatf("v%0d.miss_cnt", i), miss_cnt, vq[i].exp_mc);
    end

    // Flush in idle, then every previously cached address must miss.
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    bus.address = 32'h0000_0100;
    @(negedge clk);
    chk("flush.hit_0100", bus.hit, 1'b0);
    bus.address = 32'h0000_2000;
    #1 chk("flush.hit_2000", bus.hit, 1'b0);
    @(posedge clk);
    #1;
    xact(1'b0, 1'b0, 32'h0000_0100, 32'h0, 64'hAAAA_BBBB_1111_2222, rd, h0, cyc, sr, sw, saddr);
    chk("flush.reread_sram_cyc", sr, SRAM_LAT);
    chk("flush.reread_rdata", rd, 32'h1111_2222);
    chk("flush.miss_cnt", miss_cnt, 4'd8);

    // Hit counter must stick at 15 (8 + 10 hits would otherwise wrap to 2).
    for (int n = 0; n < 10; n++)
      xact(1'b0, 1'b0, 32'h0000_0100, 32'h0, 64'h0, rd, h0, cyc, sr, sw, saddr);
    chk("sat.hit_cnt", hit_cnt, 4'd15);
    chk("sat.rdata", rd, 32'h1111_2222);

    // Reset in the middle of a fill; a late SRAM ready must have no effect.
    resp_en = 1'b0;
    bus.address  = 32'h0000_3000;
    bus.mem_r_en = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstfill.sram_read_before", sram_read, 1'b1);
    chk("rstfill.sram_address", sram_address, 32'h0000_3000);
    rst = 1'b1;
    bus.mem_r_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstfill.sram_read_after", sram_read, 1'b0);
    chk("rstfill.ready", bus.ready, 1'b0);
    chk("rstfill.hit_cnt", hit_cnt, 4'd0);
    chk("rstfill.miss_cnt", miss_cnt, 4'd0);
    bus.address = 32'h0000_0100;
    #1 chk("rstfill.hit_0100", bus.hit, 1'b0);
    sram_rdata = 64'hFFFF_0000_FFFF_0000;
    sram_ready = 1'b1;
    #1 chk("late_ready.ready", bus.ready, 1'b0);
    @(negedge clk);
    chk("late_ready.miss_cnt", miss_cnt, 4'd0);
    chk("late_ready.sram_read", sram_read, 1'b0);
    bus.address = 32'h0000_3000;
    #1 chk("late_ready.hit_3000", bus.hit, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
